program_store: RTL and testbench

- User-loadable instruction memory and fetch sequencer, directly upstream of the CPU controller.
- Replaces the hard-coded instruction table.
- In LOAD use, each debounced button press writes the 8-bit switch value into the next memory line.
- In RUN use, it replays the stored lines in order to the controller through a valid/ack handshake, then stops.

---
 rtl/program_store.sv | 116 +++++++++++
 tb/tb_program_store.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_store.sv
// User-loadable instruction memory with a fetch sequencer that replays the
// stored lines to the CPU controller through a valid/ack handshake.
module program_store #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load_btn,
  input  logic              run_btn,
  input  logic [7:0]        sw,
  output logic [7:0]        instr_out,
  output logic              instr_valid,
  input  logic              instr_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(1);

  state_t            r_state, w_next;
  logic              r_load_q, r_run_q;
  logic [7:0]        r_mem [DEPTH];
  logic [7:0]        r_instr;
  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W:0]   r_count;

  logic              w_load_press, w_run_press;
  logic              w_full, w_last, w_write, w_handshake;

  assign w_load_press = load_btn & ~r_load_q;
  assign w_run_press  = run_btn  & ~r_run_q;
  assign w_full       = (r_count == DEPTH_C);
  assign w_last       = (({1'b0, r_pc} + ONE_C) >= r_count);
  assign w_handshake  = r_valid & instr_ack;
  // Run press beats a simultaneous load press, so no write in that case.
  assign w_write      = (r_state == S_IDLE) & w_load_press & ~w_run_press & ~w_full;

  always_ff @(posedge clk) begin
    if (!clr) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_run_press && r_count != '0) w_next = S_RUN;
      S_RUN: begin
        if (w_run_press)                w_next = S_IDLE;
        else if (w_handshake && w_last) w_next = S_DONE;
      end
      S_DONE: if (w_run_press) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_load_q <= 1'b0;
      r_run_q  <= 1'b0;
      r_count  <= '0;
      r_pc     <= '0;
      r_instr  <= 8'h00;
      r_valid  <= 1'b0;
    end else begin
      r_load_q <= load_btn;
      r_run_q  <= run_btn;
      case (r_state)
        S_IDLE: begin
          if (w_run_press)  r_pc    <= '0;
          else if (w_write) r_count <= r_count + ONE_C;
        end
        S_RUN: begin
          if (w_run_press) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
          end else if (!r_valid) begin
            // First fetch after entry; pc is already 0 here.
            r_instr <= r_mem[r_pc];
            r_valid <= 1'b1;
          end else if (instr_ack) begin
            if (w_last) begin
              r_valid <= 1'b0;
            end else begin
              r_pc    <= r_pc + PC_INC;
              r_instr <= r_mem[r_pc + PC_INC];
            end
          end
        end
        S_DONE: begin
          if (w_run_press) r_pc <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_count[ADDR_W-1:0]] <= sw;
  end

  assign instr_out   = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign count       = r_count;
  assign full        = w_full;
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_program_store.sv
// Bench for program_store: directed scenarios plus randomized programs and
// ack patterns, checked against a queue-based model of the loaded program.
module tb_program_store;

  logic       clk = 1'b0;
  logic       clr, load_btn, run_btn, instr_ack;
  logic [7:0] sw;
  logic [7:0] instr_out;
  logic       instr_valid;
  logic [3:0] pc;
  logic [4:0] count;
  logic       full, done;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         gotpc_q[$];

  program_store #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .clr(clr), .load_btn(load_btn), .run_btn(run_btn), .sw(sw),
    .instr_out(instr_out), .instr_valid(instr_valid), .instr_ack(instr_ack),
    .pc(pc), .count(count), .full(full), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b0; load_btn = 1'b0; run_btn = 1'b0; instr_ack = 1'b0; sw = 8'h00;
    tick(); tick();
    clr = 1'b1;
    exp_q.delete();
  endtask

  // The model of a load: append while fewer than 16 lines are stored.
  task automatic press_load(input logic [7:0] v);
    sw = v; load_btn = 1'b1;
    tick();
    load_btn = 1'b0;
    tick();
    if (exp_q.size() < 16) exp_q.push_back(v);
  endtask

  task automatic press_run();
    run_btn = 1'b1;
    tick();
    run_btn = 1'b0;
  endtask

  // mode 0: ack always high, mode 1: ack every gap cycles, mode 2: random ack.
  task automatic run_capture(input int mode, input int gap, input int budget);
    int         i = 0;
    int         gc = 0;
    bit         fin = 0;
    bit         hold = 0;
    logic       a;
    logic [7:0] p_instr = 8'h00;
    logic [3:0] p_pc = 4'h0;
    got_q.delete(); gotpc_q.delete();
    while (i < budget && !fin) begin
      if (hold) begin
        chk("hold_instr", 32'(instr_out), 32'(p_instr));
        chk("hold_pc", 32'(pc), 32'(p_pc));
      end
      if (done) begin
        fin = 1;
      end else begin
        if (mode == 0)      a = 1'b1;
        else if (mode == 1) a = ((gc % gap) == gap - 1);
        else                a = 1'($urandom_range(0, 1));
        gc++;
        instr_ack = a;
        if (instr_valid && a) begin
          got_q.push_back(instr_out);
          gotpc_q.push_back(int'(pc));
        end
        hold = instr_valid && !a;
        p_instr = instr_out; p_pc = pc;
        tick();
        i++;
      end
    end
    instr_ack = 1'b0;
    if (!fin) chk("run_timeout", 32'(0), 32'(1));
  endtask

  task automatic compare_prog(input string tag);
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    chk({tag, "_nlines"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < n; k++) begin
      chk({tag, "_line"}, 32'(got_q[k]), 32'(exp_q[k]));
      chk({tag, "_pc"}, 32'(gotpc_q[k]), 32'(k));
    end
    chk({tag, "_done"}, 32'(done), 32'(1));
    chk({tag, "_vld_low"}, 32'(instr_valid), 32'(0));
    if (exp_q.size() > 0) begin
      chk({tag, "_pc_last"}, 32'(pc), 32'(exp_q.size() - 1));
      chk({tag, "_out_last"}, 32'(instr_out), 32'(exp_q[exp_q.size()-1]));
    end
  endtask

  initial begin
    bit saw_valid;
    int n;

    // Reset with both buttons high.
    clr = 1'b0; load_btn = 1'b1; run_btn = 1'b1; instr_ack = 1'b0; sw = 8'h5A;
    tick(); tick();
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_valid", 32'(instr_valid), 32'(0));
    chk("rst_instr", 32'(instr_out), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_full", 32'(full), 32'(0));
    chk("rst_pc", 32'(pc), 32'(0));
    run_btn = 1'b0;
    clr = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("held_load_one_line", 32'(count), 32'(1));
    load_btn = 1'b0;

    // Three-line program, ack held high, exact cycle-by-cycle sequence.
    do_reset();
    press_load(8'h90); press_load(8'h01); press_load(8'hA4);
    chk("count3", 32'(count), 32'(3));
    press_run();
    chk("lat_vld0", 32'(instr_valid), 32'(0));
    instr_ack = 1'b1;
    tick();
    chk("seq0_v", 32'(instr_valid), 32'(1));
    chk("seq0", 32'(instr_out), 32'(8'h90));
    tick();
    chk("seq1", 32'(instr_out), 32'(8'h01));
    chk("seq1_pc", 32'(pc), 32'(1));
    tick();
    chk("seq2", 32'(instr_out), 32'(8'hA4));
    chk("seq2_v", 32'(instr_valid), 32'(1));
    tick();
    instr_ack = 1'b0;
    chk("seq_end_v", 32'(instr_valid), 32'(0));
    chk("seq_end_done", 32'(done), 32'(1));
    chk("seq_end_pc", 32'(pc), 32'(2));

    // Back to idle, then rerun with acks spaced 3 cycles apart.
    press_run();
    chk("idle_done", 32'(done), 32'(0));
    chk("idle_pc", 32'(pc), 32'(0));
    chk("idle_count", 32'(count), 32'(3));
    tick();
    press_run();
    run_capture(1, 3, 200);
    compare_prog("gap3");

    // Seventeen loads saturate at sixteen lines.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      press_load(8'hFF - 8'(k));
      if (k == 14) chk("full_at15", 32'(full), 32'(0));
      if (k == 15) begin
        chk("full_at16", 32'(full), 32'(1));
        chk("count16", 32'(count), 32'(16));
      end
    end
    chk("count_sat", 32'(count), 32'(16));
    chk("model_last", 32'(exp_q[15]), 32'(8'hF0));
    press_run();
    run_capture(2, 1, 400);
    compare_prog("full16");

    // Run press with an empty program does nothing.
    do_reset();
    press_run();
    saw_valid = 0;
    for (int k = 0; k < 6; k++) begin
      if (instr_valid || done) saw_valid = 1;
      tick();
    end
    chk("empty_run_idle", 32'(saw_valid), 32'(0));

    // Simultaneous load and run press: run wins.
    press_load(8'h11); press_load(8'h22);
    sw = 8'h33; load_btn = 1'b1; run_btn = 1'b1;
    tick();
    load_btn = 1'b0; run_btn = 1'b0;
    chk("sim_count", 32'(count), 32'(2));
    tick();
    chk("sim_run_vld", 32'(instr_valid), 32'(1));
    chk("sim_run_out", 32'(instr_out), 32'(8'h11));

    // Abort at pc=1 with a simultaneous ack, replay, then clr mid-run.
    do_reset();
    press_load(8'hC1); press_load(8'hC2); press_load(8'hC3); press_load(8'hC4);
    press_run();
    tick();
    instr_ack = 1'b1;
    tick();
    chk("abort_pre_pc", 32'(pc), 32'(1));
    run_btn = 1'b1;
    tick();
    run_btn = 1'b0; instr_ack = 1'b0;
    chk("abort_vld", 32'(instr_valid), 32'(0));
    chk("abort_pc", 32'(pc), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    tick();
    chk("abort_stays_idle", 32'(instr_valid), 32'(0));
    press_run();
    run_capture(0, 1, 200);
    compare_prog("replay");
    press_run();
    tick();
    press_run();
    tick();
    instr_ack = 1'b1;
    tick(); tick();
    instr_ack = 1'b0;
    chk("clr_pre_pc", 32'(pc), 32'(2));
    clr = 1'b0;
    tick();
    clr = 1'b1;
    chk("clr_count", 32'(count), 32'(0));
    chk("clr_vld", 32'(instr_valid), 32'(0));
    chk("clr_pc", 32'(pc), 32'(0));

    // Randomized programs and ack patterns.
    for (int it = 0; it < 5; it++) begin
      do_reset();
      n = $urandom_range(1, 16);
      for (int k = 0; k < n; k++) press_load(8'($urandom));
      chk("rnd_count", 32'(count), 32'(n));
      press_run();
      run_capture(2, 1, 400);
      compare_prog("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
